packet_transfer_arbiter: RTL and testbench

PACKET_TRANSFER_ARBITER -- requirements
Module: packet_transfer_arbiter

---
 rtl/packet_transfer_arbiter_if.sv | 28 ++
 rtl/packet_transfer_arbiter.sv | 121 ++++++++++++
 tb/tb_packet_transfer_arbiter.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/packet_transfer_arbiter_if.sv
// Requester/transfer-buffer bundle for packet_transfer_arbiter.
// The master side is the arbiter; the slave side is the requesters plus the buffer.
interface packet_transfer_arbiter_if #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned FLIT_WIDTH = 64
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*FLIT_WIDTH-1:0] req_flit;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          buf_valid;
    logic [FLIT_WIDTH-1:0]         buf_flit;
    logic                          buf_last;
    logic                          buf_ready;
    logic [NUM_REQ-1:0]            grant;
    logic                          abort;
    logic [15:0]                   pkt_count;

    modport master (
        input  req_valid, req_flit, req_last, buf_ready,
        output req_ready, buf_valid, buf_flit, buf_last, grant, abort, pkt_count
    );

    modport slave (
        output req_valid, req_flit, req_last, buf_ready,
        input  req_ready, buf_valid, buf_flit, buf_last, grant, abort, pkt_count
    );
endinterface

// File: rtl/packet_transfer_arbiter.sv
// Round-robin arbiter that hands the transfer buffer to one requester for a whole packet.
// An owner that stays silent for MAX_IDLE granted cycles is aborted.
module packet_transfer_arbiter #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned FLIT_WIDTH = 64,
    parameter int unsigned MAX_IDLE   = 16
) (
    input logic                       clk,
    input logic                       rst_n,
    packet_transfer_arbiter_if.master bus
);
    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [0:0] {StIdle, StXfer} state_e;

    state_e                r_state;
    logic [NUM_REQ-1:0]    r_grant;
    logic [IDX_W-1:0]      r_owner;
    logic [IDX_W-1:0]      r_last_owner;
    logic [7:0]            r_idle_cnt;
    logic                  r_abort;
    logic [15:0]           r_pkt_count;

    logic                  w_any_req;
    logic                  w_found;
    logic [IDX_W-1:0]      w_cand;
    logic [IDX_W-1:0]      w_winner;
    logic [NUM_REQ-1:0]    w_winner_oh;
    logic                  w_own_valid;
    logic                  w_own_last;
    logic [FLIT_WIDTH-1:0] w_own_flit;
    logic                  w_fire;

    assign w_any_req = |bus.req_valid;

    // Walk the requesters starting just after the previous owner; first valid one wins.
    always_comb begin
        w_found  = 1'b0;
        w_cand   = r_last_owner;
        w_winner = r_last_owner;
        for (int off = 0; off < int'(NUM_REQ); off++) begin
            w_cand = (w_cand == IDX_W'(NUM_REQ - 1)) ? '0 : w_cand + 1'b1;
            if (!w_found && bus.req_valid[w_cand]) begin
                w_winner = w_cand;
                w_found  = 1'b1;
            end
        end
    end

    assign w_winner_oh = NUM_REQ'(1) << w_winner;

    // Grant is all-zero outside a packet, so masking by it also zeroes the idle outputs.
    always_comb begin
        w_own_flit = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (r_grant[i]) begin
                w_own_flit = w_own_flit | bus.req_flit[i*FLIT_WIDTH +: FLIT_WIDTH];
            end
        end
    end

    assign w_own_valid = |(bus.req_valid & r_grant);
    assign w_own_last  = |(bus.req_last & r_grant);
    assign w_fire      = w_own_valid & bus.buf_ready;

    assign bus.req_ready = r_grant & {NUM_REQ{bus.buf_ready}};
    assign bus.buf_valid = w_own_valid;
    assign bus.buf_flit  = w_own_flit;
    assign bus.buf_last  = w_own_last;
    assign bus.grant     = r_grant;
    assign bus.abort     = r_abort;
    assign bus.pkt_count = r_pkt_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_grant      <= '0;
            r_owner      <= '0;
            r_last_owner <= IDX_W'(NUM_REQ - 1);
            r_idle_cnt   <= '0;
            r_abort      <= 1'b0;
            r_pkt_count  <= '0;
        end else begin
            r_abort <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_any_req) begin
                        r_state    <= StXfer;
                        r_grant    <= w_winner_oh;
                        r_owner    <= w_winner;
                        r_idle_cnt <= '0;
                    end
                end
                StXfer: begin
                    if (w_fire && w_own_last) begin
                        r_state      <= StIdle;
                        r_grant      <= '0;
                        r_last_owner <= r_owner;
                        r_pkt_count  <= r_pkt_count + 16'd1;
                        r_idle_cnt   <= '0;
                    end else if (w_own_valid) begin
                        r_idle_cnt <= '0;
                    end else if (r_idle_cnt == 8'(MAX_IDLE - 1)) begin
                        // This cycle is the MAX_IDLE-th silent one: give up on the packet.
                        r_state      <= StIdle;
                        r_grant      <= '0;
                        r_last_owner <= r_owner;
                        r_idle_cnt   <= '0;
                        r_abort      <= 1'b1;
                    end else begin
                        r_idle_cnt <= r_idle_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_grant <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_packet_transfer_arbiter.sv
// Directed bench for packet_transfer_arbiter: requester model, scoreboard of expected flits,
// and immediate-assertion checks of grant, abort and pkt_count behaviour.
module tb_packet_transfer_arbiter;
    localparam int unsigned NUM_REQ    = 2;
    localparam int unsigned FLIT_WIDTH = 64;
    localparam int unsigned MAX_IDLE   = 16;

    typedef struct packed {
        logic [63:0] flit;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    packet_transfer_arbiter_if #(.NUM_REQ(NUM_REQ), .FLIT_WIDTH(FLIT_WIDTH)) u_bus ();

    packet_transfer_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .FLIT_WIDTH(FLIT_WIDTH),
        .MAX_IDLE  (MAX_IDLE)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (u_bus)
    );

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_aborts = 0;
    bit   en[NUM_REQ];
    int   len[NUM_REQ];
    int   idx[NUM_REQ];
    int   pktn[NUM_REQ];
    bit   acc[NUM_REQ];

    function automatic logic [63:0] flit_of(input int r, input int p, input int k);
        return {8'(r), 16'(p), 16'(k), 24'hC0FFEE};
    endfunction

    task automatic check(input logic [63:0] obs, input logic [63:0] exp, input string tag);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int r = 0; r < int'(NUM_REQ); r++) begin
            u_bus.req_valid[r] = en[r];
            u_bus.req_flit[r*FLIT_WIDTH +: FLIT_WIDTH] = flit_of(r, pktn[r], idx[r]);
            u_bus.req_last[r] = (idx[r] == len[r] - 1);
        end
    endtask

    task automatic push_pkt(input int r, input int p, input int first, input int n,
                            input int plen);
        exp_t e;
        for (int k = first; k < first + n; k++) begin
            e.flit = flit_of(r, p, k);
            e.last = (k == plen - 1);
            sb_q.push_back(e);
        end
    endtask

    // One clock: score any transfer at the negedge, then advance requesters after the posedge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (u_bus.abort) n_aborts++;
        if (rst_n && u_bus.buf_valid && u_bus.buf_ready) begin
            e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
            check(u_bus.buf_flit, e.flit, "sb_flit");
            check(64'(u_bus.buf_last), 64'(e.last), "sb_last");
        end
        for (int r = 0; r < int'(NUM_REQ); r++) begin
            acc[r] = u_bus.req_valid[r] & u_bus.req_ready[r];
        end
        @(posedge clk);
        #1;
        for (int r = 0; r < int'(NUM_REQ); r++) begin
            if (acc[r]) begin
                if (idx[r] == len[r] - 1) begin
                    idx[r] = 0;
                    pktn[r]++;
                end else begin
                    idx[r]++;
                end
            end
        end
        drive();
        #1;
    endtask

    task automatic expect_grant(input logic [NUM_REQ-1:0] exp, input string tag);
        int n = 0;
        while (u_bus.grant == '0 && n < 10) begin
            tick();
            n++;
        end
        check(64'(u_bus.grant), 64'(exp), tag);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (u_bus.grant != '0 && n < 60) begin
            tick();
            n++;
        end
        check(64'(u_bus.grant), 64'(0), tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        for (int r = 0; r < int'(NUM_REQ); r++) begin
            en[r] = 1'b0; len[r] = 2; idx[r] = 0; pktn[r] = 0; acc[r] = 1'b0;
        end
        u_bus.buf_ready = 1'b1;
        drive();
        repeat (2) @(posedge clk);
        #1;
        check(64'(u_bus.grant), 64'(0), "rst_grant");
        check(64'(u_bus.abort), 64'(0), "rst_abort");
        check(64'(u_bus.pkt_count), 64'(0), "rst_pkt_count");
        check(64'(u_bus.buf_valid), 64'(0), "rst_buf_valid");
        check(64'(u_bus.req_ready), 64'(0), "rst_req_ready");

        // Both valid after reset: requester 0 first, one cycle later, 3-flit packet.
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        len[0] = 3; len[1] = 2; en[0] = 1'b1; en[1] = 1'b1;
        drive();
        push_pkt(0, 0, 0, 3, 3);
        @(posedge clk);
        #1;
        check(64'(u_bus.grant), 64'(2'b01), "first_grant_latency");
        check(u_bus.buf_flit, flit_of(0, 0, 0), "first_flit");
        check(64'(u_bus.req_ready), 64'(2'b01), "first_req_ready");
        wait_idle("pkt0_done");
        check(64'(u_bus.pkt_count), 64'(1), "pkt_count_1");
        check(64'(sb_q.size()), 64'(0), "sb_drained_1");

        // Continuous contention with 2-flit packets alternates owners.
        len[0] = 2;
        drive();
        push_pkt(1, 0, 0, 2, 2);
        push_pkt(0, 1, 0, 2, 2);
        push_pkt(1, 1, 0, 2, 2);
        push_pkt(0, 2, 0, 2, 2);
        for (int k = 0; k < 4; k++) begin
            expect_grant((k % 2 == 0) ? 2'b10 : 2'b01, "rr_grant");
            wait_idle("rr_done");
        end
        check(64'(u_bus.pkt_count), 64'(5), "pkt_count_5");
        check(64'(sb_q.size()), 64'(0), "sb_drained_2");

        // Long backpressure on a valid owner must not abort and must hold the flit.
        u_bus.buf_ready = 1'b0;
        en[0] = 1'b0;
        drive();
        push_pkt(1, 2, 0, 2, 2);
        expect_grant(2'b10, "stall_grant");
        for (int k = 0; k < 20; k++) begin
            tick();
            check(u_bus.buf_flit, flit_of(1, 2, 0), "stall_flit_held");
            check(64'(u_bus.abort), 64'(0), "stall_no_abort");
        end
        u_bus.buf_ready = 1'b1;
        drive();
        wait_idle("stall_done");
        check(64'(u_bus.pkt_count), 64'(6), "pkt_count_6");
        check(64'(n_aborts), 64'(0), "no_abort_yet");

        // Owner 0 sends one flit then goes silent; requester 1 waits behind it.
        en[0] = 1'b1; len[0] = 4;
        drive();
        push_pkt(0, 3, 0, 1, 4);
        expect_grant(2'b01, "abort_grant");
        tick();
        en[0] = 1'b0; en[1] = 1'b1; len[1] = 1;
        drive();
        push_pkt(1, 3, 0, 1, 1);
        #1;
        check(64'(u_bus.req_ready), 64'(2'b01), "other_not_ready");
        for (int k = 0; k < int'(MAX_IDLE) - 1; k++) begin
            tick();
            check(64'(u_bus.abort), 64'(0), "abort_early");
            check(64'(u_bus.grant), 64'(2'b01), "owner_held");
        end
        tick();
        check(64'(u_bus.abort), 64'(1), "abort_pulse");
        check(64'(u_bus.grant), 64'(0), "abort_grant_clear");
        check(64'(u_bus.pkt_count), 64'(6), "abort_pkt_count");
        idx[0] = 0; pktn[0] = 4;
        drive();
        tick();
        check(64'(u_bus.abort), 64'(0), "abort_one_cycle");
        check(64'(u_bus.grant), 64'(2'b10), "after_abort_grant");
        tick();
        check(64'(u_bus.grant), 64'(0), "single_flit_done");
        check(64'(u_bus.pkt_count), 64'(7), "pkt_count_7");
        check(64'(n_aborts), 64'(1), "abort_count_1");

        // Counter wrap: preload to all-ones, then one more packet.
        en[1] = 1'b0;
        drive();
        force dut.r_pkt_count = 16'hFFFF;
        #1;
        release dut.r_pkt_count;
        check(64'(u_bus.pkt_count), 64'hFFFF, "preload_ffff");
        en[0] = 1'b1; len[0] = 1;
        drive();
        push_pkt(0, 4, 0, 1, 1);
        expect_grant(2'b01, "wrap_grant");
        tick();
        check(64'(u_bus.grant), 64'(0), "wrap_done");
        check(64'(u_bus.pkt_count), 64'(0), "pkt_count_wrap");

        // Asynchronous reset in the middle of a 4-flit packet from requester 1.
        en[0] = 1'b0; en[1] = 1'b1; len[1] = 4;
        drive();
        push_pkt(1, 4, 0, 1, 4);
        expect_grant(2'b10, "reset_pkt_grant");
        tick();
        check(u_bus.buf_flit, flit_of(1, 4, 1), "second_flit_shown");
        #1;
        rst_n = 1'b0;
        #1;
        check(64'(u_bus.grant), 64'(0), "async_rst_grant");
        check(64'(u_bus.buf_valid), 64'(0), "async_rst_buf_valid");
        check(u_bus.buf_flit, 64'(0), "async_rst_buf_flit");
        check(64'(u_bus.buf_last), 64'(0), "async_rst_buf_last");
        check(64'(u_bus.req_ready), 64'(0), "async_rst_req_ready");
        check(64'(u_bus.abort), 64'(0), "async_rst_abort");
        check(64'(u_bus.pkt_count), 64'(0), "async_rst_pkt_count");
        idx[1] = 0; pktn[1] = 5;
        en[0] = 1'b1; en[1] = 1'b1; len[0] = 2; len[1] = 2;
        drive();
        push_pkt(0, 5, 0, 2, 2);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check(64'(u_bus.grant), 64'(2'b01), "post_reset_req0_first");
        wait_idle("post_reset_done");
        check(64'(u_bus.pkt_count), 64'(1), "post_reset_pkt_count");
        check(64'(n_aborts), 64'(1), "no_abort_on_reset");
        check(64'(sb_q.size()), 64'(0), "sb_drained_final");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
